// File: rtl/counter_seq_pkg.sv
// Shared definitions for the BCD/Gray counter sequencer.
//   state_e       : sequencer FSM states
//   MODE_*        : counter mode encodings driven on ctr_control
//   bin2gray      : binary -> reflected Gray
//   gray2bin      : reflected Gray -> binary
//   terminal_code : last code of a lap for a given mode and width
// Helpers work on 32-bit values; callers zero-extend and truncate to WIDTH.
package counter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RUN_BCD  = 3'd1,
    SWITCH   = 3'd2,
    RUN_GRAY = 3'd3,
    DONE     = 3'd4
  } state_e;

  localparam logic MODE_BCD  = 1'b0;
  localparam logic MODE_GRAY = 1'b1;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Binary bit i is the XOR of all Gray bits at or above i.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction

  function automatic logic [31:0] terminal_code(input logic mode, input int unsigned width);
    logic [31:0] ones;
    ones = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
    return (mode == MODE_GRAY) ? bin2gray(ones) : ones;
  endfunction

endpackage

// File: rtl/counter_seq_ctrl_code_predictor.sv
// Combinational prediction of the counter's next code.
//   mode        : MODE_BCD or MODE_GRAY
//   cur         : currently expected code
//   nxt         : successor of cur in that mode, mod 2^WIDTH
//   is_terminal : cur is the last code of a lap in that mode
module code_predictor
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             mode,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt,
  output logic             is_terminal
);

  logic [31:0]      cur_ext;
  logic [WIDTH-1:0] bin_inc;

  always_comb begin
    cur_ext = 32'(cur);
    // Wrap in binary before re-encoding so the Gray sequence closes back to 0.
    bin_inc = WIDTH'(gray2bin(cur_ext) + 32'd1);
    if (mode == MODE_GRAY) nxt = WIDTH'(bin2gray(32'(bin_inc)));
    else                   nxt = WIDTH'(cur_ext + 32'd1);
    is_terminal = (cur == WIDTH'(terminal_code(mode, WIDTH)));
  end

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for the BCD/Gray counter: resets it, runs LAPS laps in BCD,
// resets it, runs LAPS laps in Gray, checking every code and terminal flag
// against a predicted sequence.
//   clk, reset       : clock, async active-low reset
//   start            : begin a sequence (sampled in IDLE only)
//   busy, done       : sequence in progress / one-cycle completion pulse
//   err              : sticky mismatch, cleared on accepted start
//   lap_cnt          : laps completed in the current mode
//   ctr_control      : counter mode (0 BCD, 1 Gray)
//   ctr_reset        : synchronous active-high reset to the counter
//   ctr_out_flag     : counter terminal flag
//   ctr_counter      : counter value
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int LAPS  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [$clog2(LAPS+1)-1:0]  lap_cnt,
  output logic                       ctr_control,
  output logic                       ctr_reset,
  input  logic                       ctr_out_flag,
  input  logic [WIDTH-1:0]           ctr_counter
);

  localparam int LCW = $clog2(LAPS + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [LCW-1:0]   lap_cnt_q, lap_cnt_d;
  logic             err_q, err_d;

  logic             pred_mode;
  logic [WIDTH-1:0] pred_nxt;
  logic             pred_term;
  logic             last_lap;
  logic             mismatch;

  assign pred_mode = (state_q == RUN_GRAY) ? MODE_GRAY : MODE_BCD;

  code_predictor #(.WIDTH(WIDTH)) u_pred (
    .mode        (pred_mode),
    .cur         (exp_q),
    .nxt         (pred_nxt),
    .is_terminal (pred_term)
  );

  assign last_lap = (lap_cnt_q == LCW'(LAPS - 1));
  assign mismatch = (ctr_counter != exp_q) || (ctr_out_flag != pred_term);

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    lap_cnt_d = lap_cnt_q;
    err_d     = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          err_d     = 1'b0;
          lap_cnt_d = '0;
          exp_d     = '0;
          state_d   = RUN_BCD;
        end
      end
      RUN_BCD, RUN_GRAY: begin
        if (mismatch) err_d = 1'b1;
        exp_d = pred_nxt;
        // Laps are counted from the prediction so a broken flag cannot stall us.
        if (pred_term) begin
          lap_cnt_d = lap_cnt_q + LCW'(1);
          if (last_lap) state_d = (state_q == RUN_BCD) ? SWITCH : DONE;
        end
      end
      SWITCH: begin
        exp_d     = '0;
        lap_cnt_d = '0;
        state_d   = RUN_GRAY;
      end
      DONE: begin
        exp_d     = '0;
        lap_cnt_d = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      exp_q     <= '0;
      lap_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      lap_cnt_q <= lap_cnt_d;
      err_q     <= err_d;
    end
  end

  // Counter control is decoded from state only, keeping ctr_* inputs off the outputs.
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign ctr_reset   = (state_q == IDLE) || (state_q == SWITCH) || (state_q == DONE);
  assign ctr_control = (state_q == SWITCH) || (state_q == RUN_GRAY);
  assign lap_cnt     = lap_cnt_q;
  assign err         = err_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
module tb_counter_seq_ctrl;

  localparam int WIDTH   = 3;
  localparam int LAPS    = 2;
  localparam int LAP_LEN = 1 << WIDTH;
  localparam int SEQ_LEN = 2 * LAPS * LAP_LEN + 2;   // start edge to done
  localparam int GRAY_C0 = LAPS * LAP_LEN + 2;       // first RUN_GRAY cycle
  localparam int WIN     = SEQ_LEN + 6;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic busy, done, err, ctr_control, ctr_reset, ctr_out_flag;
  logic [$clog2(LAPS+1)-1:0] lap_cnt;
  logic [WIDTH-1:0] ctr_counter;

  int vectors = 0, miscompares = 0;

  counter_seq_ctrl #(.WIDTH(WIDTH), .LAPS(LAPS)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .err(err),
    .lap_cnt(lap_cnt), .ctr_control(ctr_control), .ctr_reset(ctr_reset),
    .ctr_out_flag(ctr_out_flag), .ctr_counter(ctr_counter)
  );

  always #5 clk = ~clk;

  // Golden counter: binary count, presented as binary or Gray, with fault knobs.
  logic [WIDTH-1:0] bcnt = '0, code;
  logic             corrupt_en = 1'b0, stuck_en = 1'b0;
  logic [WIDTH-1:0] corrupt_tgt = '0, corrupt_val = '0;

  always @(posedge clk) bcnt <= ctr_reset ? '0 : bcnt + WIDTH'(1);

  always_comb begin
    code         = ctr_control ? (bcnt ^ (bcnt >> 1)) : bcnt;
    ctr_counter  = (corrupt_en && ctr_control && code == corrupt_tgt) ? corrupt_val : code;
    ctr_out_flag = stuck_en ? 1'b0 : (bcnt == '1);
  end

  // Observations of one sequence, cycle 1 = first cycle after the start edge.
  logic [WIDTH-1:0] obs_q[$];
  int o_lat, o_done_cnt, o_busy_n, o_err_at, o_err_c1, o_err_end, o_lap9, o_lap17, o_lap34;

  task automatic run_seq(input int pulse_at);
    obs_q.delete();
    o_lat = -1; o_done_cnt = 0; o_busy_n = 0; o_err_at = -1;
    o_err_c1 = -1; o_err_end = -1; o_lap9 = -1; o_lap17 = -1; o_lap34 = -1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= WIN; c++) begin
      if (busy && !ctr_reset) obs_q.push_back(ctr_counter);
      if (done) begin o_done_cnt++; if (o_lat < 0) o_lat = c; end
      if (busy) o_busy_n++;
      if (err === 1'b1 && o_err_at < 0) o_err_at = c;
      if (c == 1) o_err_c1 = int'(err);
      if (c == LAP_LEN + 1) o_lap9 = int'(lap_cnt);
      if (c == LAPS * LAP_LEN + 1) o_lap17 = int'(lap_cnt);
      if (c == SEQ_LEN) o_lap34 = int'(lap_cnt);
      if (c == WIN) o_err_end = int'(err);
      start = (c == pulse_at);
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic idle_gap();
    repeat ($urandom_range(0, 5)) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
    vectors++; if (lap_cnt !== '0) begin miscompares++; $display("FAIL reset_lap: got %0d want 0", lap_cnt); end
    vectors++; if (ctr_reset !== 1'b1) begin miscompares++; $display("FAIL reset_ctr_reset: got %b want 1", ctr_reset); end
    vectors++; if (ctr_control !== 1'b0) begin miscompares++; $display("FAIL reset_ctr_control: got %b want 0", ctr_control); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean();
    int k, ev;
    logic [WIDTH-1:0] got;
    idle_gap();
    run_seq(-1);
    vectors++; if (o_lat != SEQ_LEN) begin miscompares++; $display("FAIL clean_done_lat: got %0d want %0d", o_lat, SEQ_LEN); end
    vectors++; if (o_done_cnt != 1) begin miscompares++; $display("FAIL clean_done_cnt: got %0d want 1", o_done_cnt); end
    vectors++; if (o_busy_n != SEQ_LEN) begin miscompares++; $display("FAIL clean_busy_len: got %0d want %0d", o_busy_n, SEQ_LEN); end
    vectors++; if (o_err_at != -1) begin miscompares++; $display("FAIL clean_err: got err at %0d want never", o_err_at); end
    vectors++; if (o_lap9 != 1) begin miscompares++; $display("FAIL clean_lap_mid: got %0d want 1", o_lap9); end
    vectors++; if (o_lap17 != LAPS) begin miscompares++; $display("FAIL clean_lap_switch: got %0d want %0d", o_lap17, LAPS); end
    vectors++; if (o_lap34 != LAPS) begin miscompares++; $display("FAIL clean_lap_done: got %0d want %0d", o_lap34, LAPS); end
    vectors++; if (obs_q.size() != 2 * LAPS * LAP_LEN) begin miscompares++; $display("FAIL clean_seq_len: got %0d want %0d", obs_q.size(), 2 * LAPS * LAP_LEN); end
    k = 0;
    for (int m = 0; m < 2; m++)
      for (int l = 0; l < LAPS; l++)
        for (int i = 0; i < LAP_LEN; i++) begin
          ev  = (m == 1) ? (i ^ (i >> 1)) : i;
          got = (k < obs_q.size()) ? obs_q[k] : 'x;
          vectors++;
          if (got !== WIDTH'(ev)) begin miscompares++; $display("FAIL clean_seq[%0d]: got %0d want %0d", k, got, ev); end
          k++;
        end
  endtask

  task automatic test_gray_corrupt();
    int idx, want;
    corrupt_tgt = WIDTH'($urandom_range(0, LAP_LEN - 1));
    corrupt_val = corrupt_tgt ^ WIDTH'(1 << $urandom_range(0, WIDTH - 1));
    idx = 0;
    for (int i = 0; i < LAP_LEN; i++) if ((i ^ (i >> 1)) == int'(corrupt_tgt)) idx = i;
    want = GRAY_C0 + idx + 1;
    corrupt_en = 1'b1;
    idle_gap();
    run_seq(-1);
    corrupt_en = 1'b0;
    vectors++; if (o_err_at != want) begin miscompares++; $display("FAIL corrupt_err_rise: got %0d want %0d", o_err_at, want); end
    vectors++; if (o_lat != SEQ_LEN) begin miscompares++; $display("FAIL corrupt_done_lat: got %0d want %0d", o_lat, SEQ_LEN); end
    vectors++; if (o_err_end != 1) begin miscompares++; $display("FAIL corrupt_err_held: got %0d want 1", o_err_end); end
    idle_gap();
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL corrupt_err_idle: got %b want 1", err); end
    run_seq(-1);
    vectors++; if (o_err_c1 != 0) begin miscompares++; $display("FAIL restart_err_clear: got %0d want 0", o_err_c1); end
    vectors++; if (o_err_at != -1) begin miscompares++; $display("FAIL restart_err: got err at %0d want never", o_err_at); end
  endtask

  task automatic test_flag_stuck();
    stuck_en = 1'b1;
    idle_gap();
    run_seq(-1);
    stuck_en = 1'b0;
    vectors++; if (o_err_at != LAP_LEN + 1) begin miscompares++; $display("FAIL stuck_err_rise: got %0d want %0d", o_err_at, LAP_LEN + 1); end
    vectors++; if (o_lap17 != LAPS) begin miscompares++; $display("FAIL stuck_lap_switch: got %0d want %0d", o_lap17, LAPS); end
    vectors++; if (o_lap34 != LAPS) begin miscompares++; $display("FAIL stuck_lap_done: got %0d want %0d", o_lap34, LAPS); end
    vectors++; if (o_lat != SEQ_LEN) begin miscompares++; $display("FAIL stuck_done_lat: got %0d want %0d", o_lat, SEQ_LEN); end
  endtask

  task automatic test_start_ignored();
    int p;
    p = $urandom_range(GRAY_C0, SEQ_LEN - 1);
    idle_gap();
    run_seq(p);
    vectors++; if (o_done_cnt != 1) begin miscompares++; $display("FAIL ignore_done_cnt: got %0d want 1 (pulse at %0d)", o_done_cnt, p); end
    vectors++; if (o_lat != SEQ_LEN) begin miscompares++; $display("FAIL ignore_done_lat: got %0d want %0d", o_lat, SEQ_LEN); end
    vectors++; if (o_busy_n != SEQ_LEN) begin miscompares++; $display("FAIL ignore_busy_len: got %0d want %0d", o_busy_n, SEQ_LEN); end
  endtask

  task automatic test_back_to_back();
    int d1 = -1, d2 = -1, dn = 0;
    logic b_gap = 1'bx, b_re = 1'bx, r_re = 1'bx;
    idle_gap();
    start = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 2 * SEQ_LEN + 4; c++) begin
      if (done) begin dn++; if (d1 < 0) d1 = c; else if (d2 < 0) d2 = c; end
      if (c == SEQ_LEN + 1) b_gap = busy;
      if (c == SEQ_LEN + 2) begin b_re = busy; r_re = ctr_reset; end
      if (c == SEQ_LEN + 6) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    vectors++; if (dn != 2) begin miscompares++; $display("FAIL b2b_done_cnt: got %0d want 2", dn); end
    vectors++; if (d1 != SEQ_LEN) begin miscompares++; $display("FAIL b2b_done1: got %0d want %0d", d1, SEQ_LEN); end
    vectors++; if (d2 != 2 * SEQ_LEN + 1) begin miscompares++; $display("FAIL b2b_done2: got %0d want %0d", d2, 2 * SEQ_LEN + 1); end
    vectors++; if (b_gap !== 1'b0) begin miscompares++; $display("FAIL b2b_idle_gap: got busy %b want 0", b_gap); end
    vectors++; if (b_re !== 1'b1 || r_re !== 1'b0) begin miscompares++; $display("FAIL b2b_rerun: got busy %b ctr_reset %b want 1 0", b_re, r_re); end
  endtask

  task automatic test_reset_mid();
    int w = 0, dseen = 0;
    idle_gap();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (lap_cnt !== 1 && w < 4 * LAP_LEN) begin @(negedge clk); w++; end
    vectors++; if (lap_cnt !== 1) begin miscompares++; $display("FAIL mid_wait_lap: got %0d want 1", lap_cnt); end
    reset = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
    vectors++; if (ctr_reset !== 1'b1) begin miscompares++; $display("FAIL mid_ctr_reset: got %b want 1", ctr_reset); end
    vectors++; if (lap_cnt !== '0) begin miscompares++; $display("FAIL mid_lap: got %0d want 0", lap_cnt); end
    vectors++; if (ctr_control !== 1'b0 || err !== 1'b0) begin miscompares++; $display("FAIL mid_ctrl_err: got %b %b want 0 0", ctr_control, err); end
    repeat (4) begin @(negedge clk); if (done !== 1'b0) dseen++; end
    vectors++; if (dseen != 0) begin miscompares++; $display("FAIL mid_no_done: got %0d want 0", dseen); end
    reset = 1'b1;
    @(negedge clk);
    run_seq(-1);
    vectors++; if (o_lat != SEQ_LEN) begin miscompares++; $display("FAIL mid_rerun_lat: got %0d want %0d", o_lat, SEQ_LEN); end
    vectors++; if (o_busy_n != SEQ_LEN) begin miscompares++; $display("FAIL mid_rerun_busy: got %0d want %0d", o_busy_n, SEQ_LEN); end
    vectors++; if (o_err_at != -1) begin miscompares++; $display("FAIL mid_rerun_err: got err at %0d want never", o_err_at); end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_gray_corrupt();
    test_gray_corrupt();
    test_flag_stuck();
    test_start_ignored();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_clean();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
